// File: rtl/sgdh_intersection_sched.sv
// Two-direction intersection scheduler: green -> yellow -> all-red per direction,
// round-robin between directions, with registered lamp outputs decoded from the next state.
module sgdh_intersection_sched #(
    parameter int GREEN_TIME  = 4*125000000,
    parameter int YELLOW_TIME = 1*125000000,
    parameter int ALLRED_TIME = 1*125000000,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       enable,
    input  logic       req_c0,
    input  logic       req_c1,
    output logic [2:0] light_c0,
    output logic [2:0] light_c1,
    output logic       grant_dir,
    output logic       phase_pulse
);

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TIME - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        G0   = 3'd1,
        Y0   = 3'd2,
        AR0  = 3'd3,
        G1   = 3'd4,
        Y1   = 3'd5,
        AR1  = 3'd6
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic             grant_next;
    logic             state_change;
    logic [CNT_W-1:0] timer_last;

    // Lamp decode for one direction; red unless that direction owns a green/yellow phase.
    function automatic logic [2:0] lamp_of(input state_t s, input logic dir);
        logic [2:0] lamp;
        lamp = LAMP_RED;
        unique case (s)
            G0:      lamp = (dir == 1'b0) ? LAMP_GREEN  : LAMP_RED;
            Y0:      lamp = (dir == 1'b0) ? LAMP_YELLOW : LAMP_RED;
            G1:      lamp = (dir == 1'b1) ? LAMP_GREEN  : LAMP_RED;
            Y1:      lamp = (dir == 1'b1) ? LAMP_YELLOW : LAMP_RED;
            default: lamp = LAMP_RED;
        endcase
        return lamp;
    endfunction

    // Terminal timer value for the current state; IDLE never counts.
    always_comb begin
        timer_last = '0;
        unique case (state)
            G0, G1:   timer_last = GREEN_LAST;
            Y0, Y1:   timer_last = YELLOW_LAST;
            AR0, AR1: timer_last = ALLRED_LAST;
            default:  timer_last = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                // Round robin: the direction that did not hold the crossing last wins a tie.
                if (enable && (req_c0 || req_c1)) begin
                    if (grant_dir)
                        state_next = req_c0 ? G0 : G1;
                    else
                        state_next = req_c1 ? G1 : G0;
                end
            end
            G0: begin
                if ((timer == GREEN_LAST) && (req_c1 || !enable))
                    state_next = Y0;
            end
            Y0: begin
                if (timer == YELLOW_LAST)
                    state_next = AR0;
            end
            AR0: begin
                if (timer == ALLRED_LAST) begin
                    if (!enable)
                        state_next = IDLE;
                    else if (req_c1)
                        state_next = G1;
                    else if (req_c0)
                        state_next = G0;
                    else
                        state_next = IDLE;
                end
            end
            G1: begin
                if ((timer == GREEN_LAST) && (req_c0 || !enable))
                    state_next = Y1;
            end
            Y1: begin
                if (timer == YELLOW_LAST)
                    state_next = AR1;
            end
            AR1: begin
                if (timer == ALLRED_LAST) begin
                    if (!enable)
                        state_next = IDLE;
                    else if (req_c0)
                        state_next = G0;
                    else if (req_c1)
                        state_next = G1;
                    else
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign state_change = (state_next != state);

    // Timer restarts on every state change and saturates at its terminal value.
    always_comb begin
        timer_next = timer;
        if (state_change || (state == IDLE))
            timer_next = '0;
        else if (timer != timer_last)
            timer_next = timer + CNT_W'(1);
    end

    always_comb begin
        grant_next = grant_dir;
        if (state_change && (state_next == G0))
            grant_next = 1'b0;
        else if (state_change && (state_next == G1))
            grant_next = 1'b1;
    end

    // Outputs are registered from the next state so lamps and pulse align with the state register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            timer       <= '0;
            grant_dir   <= 1'b1;
            light_c0    <= LAMP_RED;
            light_c1    <= LAMP_RED;
            phase_pulse <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            grant_dir   <= grant_next;
            light_c0    <= lamp_of(state_next, 1'b0);
            light_c1    <= lamp_of(state_next, 1'b1);
            phase_pulse <= state_change;
        end
    end

endmodule
